// File: rtl/fft_pkg.sv
// Shared constants and helpers for the radix-2^2 SDF FFT sequencer and its stages.
package fft_pkg;

  localparam int unsigned LOG2N_DEF     = 8;
  localparam int unsigned STAGE_LAT_DEF = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned num_stages(input int unsigned log2n);
    return log2n / 2;
  endfunction

  // Enabled cycles from the first input sample to the first valid output.
  function automatic int unsigned fill_max(input int unsigned log2n, input int unsigned lat);
    return (32'd1 << log2n) - 1 + num_stages(log2n) * lat;
  endfunction

  localparam int unsigned NS = num_stages(LOG2N_DEF);
  localparam int unsigned L  = fill_max(LOG2N_DEF, STAGE_LAT_DEF);

  // Quadrant of the stage sub-counter to twiddle exponent multiplier.
  function automatic logic [1:0] tw_quad(input logic [1:0] top);
    logic [1:0] q;
    unique case (top)
      2'b00:   q = 2'd0;
      2'b01:   q = 2'd2;
      2'b10:   q = 2'd1;
      default: q = 2'd3;
    endcase
    return q;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r = r | (((x >> i) & 32'd1) << (w - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_tw_addr_gen.sv
// Twiddle ROM address decode for one SDF stage from that stage's sample counter.
module fft_tw_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 8,
  parameter int unsigned STAGE = 0
) (
  input  logic [LOG2N-1:0] cs_i,
  output logic [LOG2N-1:0] addr_o
);

  localparam int unsigned NumStages = num_stages(LOG2N);

  if (STAGE + 1 < NumStages) begin : g_tw
    // Sub-counter width for this stage: M = N >> 2*STAGE.
    localparam int unsigned MW = LOG2N - 2 * STAGE;

    logic [MW-1:0]    w_m;
    logic [1:0]       w_q;
    logic [LOG2N-1:0] w_prod;

    assign w_m    = MW'(cs_i);
    assign w_q    = tw_quad(w_m[MW-1 -: 2]);
    // (m mod M/4) * q < M, so the product never overflows LOG2N bits.
    assign w_prod = LOG2N'(w_m[MW-3:0]) * LOG2N'(w_q);
    assign addr_o = w_prod << (2 * STAGE);
  end else begin : g_last
    logic w_unused_cs;
    assign w_unused_cs = ^cs_i;
    assign addr_o      = '0;
  end

endmodule

// File: rtl/fft_r22sdf_ctrl.sv
// Sequencer for an N-point radix-2^2 SDF FFT: sample counting, per-stage control decode,
// and output valid/frame-start/bin-index flagging.
module fft_r22sdf_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N     = 8,
  parameter int unsigned STAGE_LAT = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_n,
  input  logic                              valid_i,
  input  logic                              sof_i,
  output logic                              en_o,
  output logic [num_stages(LOG2N)-1:0]       bfi_sel_o,
  output logic [num_stages(LOG2N)-1:0]       bfii_sel_o,
  output logic [num_stages(LOG2N)-1:0]       bfii_tsel_o,
  output logic [num_stages(LOG2N)*LOG2N-1:0] tw_addr_o,
  output logic                              valid_o,
  output logic                              sof_o,
  output logic [LOG2N-1:0]                  idx_o
);

  localparam int unsigned NumSt  = num_stages(LOG2N);
  localparam int unsigned FillL  = fill_max(LOG2N, STAGE_LAT);
  localparam int unsigned FW     = clog2(FillL + 1);
  localparam logic [FW-1:0]    FillMax = FW'(FillL);
  localparam logic [LOG2N-1:0] OutOff  = LOG2N'(NumSt * STAGE_LAT);

  logic [LOG2N-1:0] r_ctr;
  logic [FW-1:0]    r_fill;

  logic                   w_act;
  logic                   w_restart;
  logic [LOG2N-1:0]       w_c;
  logic [FW-1:0]          w_fill_eff;
  logic [LOG2N-1:0]       w_cs [NumSt];
  logic [NumSt-1:0]       w_bfi;
  logic [NumSt-1:0]       w_bsel;
  logic [NumSt*LOG2N-1:0] w_tw;
  logic [LOG2N-1:0]       w_oc;
  logic [LOG2N-1:0]       w_idx;
  logic                   w_valid;

  assign w_act     = valid_i & rst_n;
  assign w_restart = valid_i & sof_i;
  assign w_c       = w_restart ? '0 : r_ctr;
  // A restart sample belongs to the new frame, so the old fill level never flags it valid.
  assign w_fill_eff = w_restart ? '0 : r_fill;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_ctr  <= '0;
      r_fill <= '0;
    end else if (valid_i) begin
      r_ctr <= w_c + LOG2N'(1);
      if (w_restart) begin
        r_fill <= FW'(1);
      end else if (r_fill != FillMax) begin
        r_fill <= r_fill + FW'(1);
      end
    end
  end

  for (genvar gs = 0; gs < NumSt; gs++) begin : g_stage
    assign w_cs[gs]   = w_c - LOG2N'(gs * STAGE_LAT);
    assign w_bfi[gs]  = w_cs[gs][LOG2N-1-2*gs];
    assign w_bsel[gs] = w_cs[gs][LOG2N-2-2*gs];

    fft_tw_addr_gen #(
      .LOG2N (LOG2N),
      .STAGE (gs)
    ) u_tw_addr_gen (
      .cs_i   (w_cs[gs]),
      .addr_o (w_tw[gs*LOG2N +: LOG2N])
    );
  end

  assign w_oc    = w_c + LOG2N'(1) - OutOff;
  assign w_idx   = LOG2N'(bitrev(32'(w_oc), LOG2N));
  assign w_valid = (w_fill_eff == FillMax);

  always_comb begin
    en_o        = 1'b0;
    bfi_sel_o   = '0;
    bfii_sel_o  = '0;
    bfii_tsel_o = '0;
    tw_addr_o   = '0;
    valid_o     = 1'b0;
    sof_o       = 1'b0;
    idx_o       = '0;
    if (w_act) begin
      en_o        = 1'b1;
      bfi_sel_o   = w_bfi;
      bfii_sel_o  = w_bsel;
      bfii_tsel_o = w_bfi;
      tw_addr_o   = w_tw;
      valid_o     = w_valid;
      sof_o       = w_valid & (w_oc == '0);
      idx_o       = w_idx;
    end
  end

endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Self-checking bench: two sequencer configurations against an arithmetic reference model.
module tb_fft_r22sdf_ctrl;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bfi;
    logic [31:0] bsel;
    logic [31:0] tsel;
    logic [31:0] tw;
    logic [31:0] vo;
    logic [31:0] so;
    logic [31:0] idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i = 1'b0;
  logic sof_i = 1'b0;

  logic       a_en, a_vo, a_so;
  logic [1:0] a_bfi, a_bsel, a_tsel;
  logic [7:0] a_tw;
  logic [3:0] a_idx;

  logic        b_en, b_vo, b_so;
  logic [2:0]  b_bfi, b_bsel, b_tsel;
  logic [17:0] b_tw;
  logic [5:0]  b_idx;

  int n_checks = 0;
  int n_errors = 0;

  int m_ctr[2];
  int m_seen[2];
  obs_t snap_a, snap_b;

  always #5 clk = ~clk;

  fft_r22sdf_ctrl #(.LOG2N(4), .STAGE_LAT(1)) u_dut_a (
    .clk_i (clk), .rst_n (rst_n), .valid_i (valid_i), .sof_i (sof_i),
    .en_o (a_en), .bfi_sel_o (a_bfi), .bfii_sel_o (a_bsel), .bfii_tsel_o (a_tsel),
    .tw_addr_o (a_tw), .valid_o (a_vo), .sof_o (a_so), .idx_o (a_idx)
  );

  fft_r22sdf_ctrl #(.LOG2N(6), .STAGE_LAT(2)) u_dut_b (
    .clk_i (clk), .rst_n (rst_n), .valid_i (valid_i), .sof_i (sof_i),
    .en_o (b_en), .bfi_sel_o (b_bfi), .bfii_sel_o (b_bsel), .bfii_tsel_o (b_tsel),
    .tw_addr_o (b_tw), .valid_o (b_vo), .sof_o (b_so), .idx_o (b_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int cfg_lg(input int d);
    return (d == 0) ? 4 : 6;
  endfunction

  function automatic int cfg_lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Expected outputs straight from the decode rules, using plain integer arithmetic.
  function automatic obs_t model_out(input int d, input logic v, input logic s, input logic r);
    obs_t e;
    int lg, lt, n, ns, lim, c, pos, cs, mm, qd, qq, oc;
    e   = '0;
    lg  = cfg_lg(d);
    lt  = cfg_lat(d);
    n   = 1 << lg;
    ns  = lg / 2;
    lim = n - 1 + ns * lt;
    if (v !== 1'b1 || r !== 1'b1) return e;
    c    = s ? 0 : m_ctr[d];
    pos  = s ? 1 : m_seen[d] + 1;
    e.en = 32'd1;
    for (int st = 0; st < ns; st++) begin
      cs = ((c - st * lt) % n + n) % n;
      if ((cs / (n >> (2 * st + 1))) % 2 == 1) begin
        e.bfi  = e.bfi | (32'd1 << st);
        e.tsel = e.tsel | (32'd1 << st);
      end
      if ((cs / (n >> (2 * st + 2))) % 2 == 1) e.bsel = e.bsel | (32'd1 << st);
      if (st < ns - 1) begin
        mm = cs % (n >> (2 * st));
        qd = mm / (n >> (2 * st + 2));
        qq = (qd == 1) ? 2 : (qd == 2) ? 1 : qd;
        e.tw = e.tw | (32'((mm % (n >> (2 * st + 2))) * qq * (1 << (2 * st))) << (st * lg));
      end
    end
    oc = ((c + 1 - ns * lt) % n + n) % n;
    for (int b = 0; b < lg; b++) begin
      if (((oc >> b) & 1) == 1) e.idx = e.idx | (32'd1 << (lg - 1 - b));
    end
    e.vo = 32'(pos > lim);
    e.so = 32'((pos > lim) && (oc == 0));
    return e;
  endfunction

  function automatic void model_step(input int d, input logic v, input logic s, input logic r);
    int n, lim, c, pos;
    n   = 1 << cfg_lg(d);
    lim = n - 1 + (cfg_lg(d) / 2) * cfg_lat(d);
    if (r !== 1'b1) begin
      m_ctr[d]  = 0;
      m_seen[d] = 0;
    end else if (v === 1'b1) begin
      c         = s ? 0 : m_ctr[d];
      pos       = s ? 1 : m_seen[d] + 1;
      m_ctr[d]  = (c + 1) % n;
      m_seen[d] = (pos > lim) ? lim + 1 : pos;
    end
  endfunction

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o = '{32'(a_en), 32'(a_bfi), 32'(a_bsel), 32'(a_tsel), 32'(a_tw), 32'(a_vo),
            32'(a_so), 32'(a_idx)};
    end else begin
      o = '{32'(b_en), 32'(b_bfi), 32'(b_bsel), 32'(b_tsel), 32'(b_tw), 32'(b_vo),
            32'(b_so), 32'(b_idx)};
    end
    return o;
  endfunction

  // One clock: drive on the falling edge, compare mid-cycle, advance the model at the rising edge.
  task automatic drive(input logic v, input logic s, input logic r);
    obs_t e, o;
    @(negedge clk);
    valid_i = v;
    sof_i   = s;
    rst_n   = r;
    #1;
    for (int d = 0; d < 2; d++) begin
      e = model_out(d, v, s, r);
      o = get_obs(d);
      check_eq($sformatf("d%0d en_o", d), o.en, e.en);
      check_eq($sformatf("d%0d bfi_sel_o", d), o.bfi, e.bfi);
      check_eq($sformatf("d%0d bfii_sel_o", d), o.bsel, e.bsel);
      check_eq($sformatf("d%0d bfii_tsel_o", d), o.tsel, e.tsel);
      check_eq($sformatf("d%0d tw_addr_o", d), o.tw, e.tw);
      check_eq($sformatf("d%0d valid_o", d), o.vo, e.vo);
      check_eq($sformatf("d%0d sof_o", d), o.so, e.so);
      check_eq($sformatf("d%0d idx_o", d), o.idx, e.idx);
    end
    snap_a = get_obs(0);
    snap_b = get_obs(1);
    @(posedge clk);
    model_step(0, v, s, r);
    model_step(1, v, s, r);
  endtask

  initial begin
    logic [3:0] tw_exp [16];
    logic [3:0] idx_exp [5];
    int first_a, first_b, found, guard;

    tw_exp  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd4, 4'd6,
                4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd3, 4'd6, 4'd9};
    idx_exp = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2};
    m_ctr   = '{0, 0};
    m_seen  = '{0, 0};

    // Reset with valid_i high: every output must stay 0.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);

    // Continuous stream, sof on the first sample.
    first_a = 0;
    first_b = 0;
    for (int i = 1; i <= 72; i++) begin
      drive(1'b1, (i == 1), 1'b1);
      if (i <= 16) begin
        check_eq("tw slice0", snap_a.tw & 32'hf, 32'(tw_exp[i-1]));
        check_eq("tw slice1", snap_a.tw >> 4, 32'd0);
      end
      if (first_a == 0 && snap_a.vo == 32'd1) first_a = i;
      if (first_b == 0 && snap_b.vo == 32'd1) first_b = i;
      if (i >= 18 && i <= 22) check_eq("idx sequence", snap_a.idx, 32'(idx_exp[i-18]));
    end
    check_eq("first valid_o cycle L=17", 32'(first_a), 32'd18);
    check_eq("first valid_o cycle L=69", 32'(first_b), 32'd70);

    // Stall for 5 cycles (a stray sof without valid is ignored), then resume.
    for (int i = 0; i < 5; i++) drive(1'b0, (i == 2), 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1);

    // Restart mid-frame at index 6; sof sample is enabled cycle 1, output returns on cycle L+1.
    guard = 0;
    while (m_ctr[0] != 6 && guard < 40) begin
      drive(1'b1, 1'b0, 1'b1);
      guard++;
    end
    check_eq("reach c=6", 32'(m_ctr[0]), 32'd6);
    drive(1'b1, 1'b1, 1'b1);
    check_eq("restart valid_o", snap_a.vo, 32'd0);
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (found == 0 && snap_a.so == 32'd1) found = k;
    end
    check_eq("sof_o after restart", 32'(found), 32'd17);

    // One-cycle reset mid-stream; next sample is index 0 without sof.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    check_eq("post-reset bfi_sel", snap_a.bfi, 32'd2);
    check_eq("post-reset idx", snap_a.idx, 32'd15);

    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 299) == 0),
            ($urandom_range(0, 399) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
